// File: rtl/mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: result = a * b * 2^-WIDTH mod n.
// Define MONT_CHECK_EN to add the err port and operand validity checks.
module mont_mul #(
    parameter int WIDTH = 4096,
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             busy,
`ifdef MONT_CHECK_EN
    output logic             done,
    output logic             err
`else
    output logic             done
`endif
);

    localparam int SW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SUB,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SW-1:0]    s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SW-1:0]    n_ext;
    logic [SW-1:0]    b_ext;
    logic [SW-1:0]    t_add;
    logic [SW-1:0]    t_red;
    logic [WIDTH-1:0] s_sub;
    logic             last_iter;
    logic             s_ge_n;

`ifdef MONT_CHECK_EN
    logic err_q, err_d;
    logic bad_in;

    assign bad_in = !n[0] || (a >= n) || (b >= n);
    assign err    = err_q;
`endif

    assign n_ext     = {2'b00, n_q};
    assign b_ext     = {2'b00, b_q};
    // S < 2n and b < n keep both partial sums below 4n, inside WIDTH+2 bits
    assign t_add     = s_q + (a_q[0] ? b_ext : '0);
    assign t_red     = t_add + (t_add[0] ? n_ext : '0);
    assign s_ge_n    = s_q >= n_ext;
    // reduced value is below n, so the low WIDTH bits carry the whole difference
    assign s_sub     = s_q[WIDTH-1:0] - n_q;
    assign last_iter = cnt_q == CNT_W'(WIDTH - 1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
`ifdef MONT_CHECK_EN
        err_d    = err_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    a_d     = a;
                    b_d     = b;
                    n_d     = n;
                    s_d     = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ITER;
`ifdef MONT_CHECK_EN
                    err_d   = bad_in;
                    if (bad_in) begin
                        state_d = SUB;
                    end
`endif
                end
            end
            ITER: begin
                s_d   = t_red >> 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                result_d = s_ge_n ? s_sub : s_q[WIDTH-1:0];
`ifdef MONT_CHECK_EN
                if (err_q) begin
                    result_d = '0;
                end
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MONT_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MONT_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mont_mul.sv
// Self-checking bench for mont_mul at WIDTH=8 (R=256).
// Reference model solves x*R == a*b (mod n) by search, independent of the datapath.
module tb_mont_mul;

    localparam int W  = 8;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         go = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] n = 8'd1;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
`ifdef MONT_CHECK_EN
    logic         err;
`endif

    mont_mul #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go),
        .a      (a),
        .b      (b),
        .n      (n),
        .result (result),
        .busy   (busy),
`ifdef MONT_CHECK_EN
        .done   (done),
        .err    (err)
`else
        .done   (done)
`endif
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int mont_ref(input int aa, input int bb, input int nn);
        int prod;
        prod = (aa * bb) % nn;
        for (int x = 0; x < nn; x++)
            if (((x * (1 << W)) % nn) == prod) return x;
        return 0;
    endfunction

    // Transaction-level model: an accepted go yields the product W+1 edges later
    int           rem;
    logic [W-1:0] m_res;
    logic [W-1:0] m_pend;
    logic         m_busy;
    logic         m_done;
    logic         m_err;
    logic         inval;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem = 0;
            m_res = '0;
            m_pend = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_err = 1'b0;
        end else if (go && !m_busy) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            inval = 1'b0;
`ifdef MONT_CHECK_EN
            inval = !n[0] || a >= n || b >= n;
`endif
            m_err = inval;
            if (inval) begin
                rem = 1;
                m_pend = '0;
            end else begin
                rem = W + 1;
                m_pend = W'(mont_ref(int'(a), int'(b), int'(n)));
            end
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_res = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
            check("cyc_result", result, m_res);
`ifdef MONT_CHECK_EN
            check("cyc_err", err, m_err);
`endif
        end
    end

    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [W-1:0] nn, input logic [W-1:0] exp,
                          input string nm, input int pulse_at);
        int j;
        @(negedge clk);
        a = aa;
        b = bb;
        n = nn;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        a = ~aa;
        b = ~bb;
        n = ~nn;
        j = 0;
        check({nm, "_drop"}, done, 0);
        while (!done && j < 40) begin
            if (j == pulse_at) begin
                go = 1'b1;
                a = 8'd5;
                b = 8'd7;
                n = 8'd13;
            end
            @(negedge clk);
            j++;
            go = 1'b0;
        end
        check({nm, "_lat"}, j, W + 1);
        check({nm, "_res"}, result, exp);
    endtask

    initial begin
        #1;
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd9, 8'd9, 8'd13, 8'd9, "sq_one", -1);
        run_op(8'd5, 8'd7, 8'd13, 8'd1, "m5x7", -1);
        run_op(8'd12, 8'd12, 8'd13, 8'd3, "m12x12", -1);
        run_op(8'd0, 8'd7, 8'd13, 8'd0, "zero_a", -1);
        run_op(8'd254, 8'd254, 8'd255, 8'd1, "top", -1);
        run_op(8'd9, 8'd9, 8'd13, 8'd9, "busy_go", 3);
        run_op(8'd12, 8'd12, 8'd13, 8'd3, "restart", -1);

        @(negedge clk);
        a = 8'd9;
        b = 8'd9;
        n = 8'd13;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd5, 8'd7, 8'd13, 8'd1, "post_rst", -1);

        for (int i = 0; i < 16; i++) begin
            int nn, aa, bb;
            nn = $urandom_range(1, 127) * 2 + 1;
            aa = $urandom_range(0, nn - 1);
            bb = $urandom_range(0, nn - 1);
            run_op(W'(aa), W'(bb), W'(nn), W'(mont_ref(aa, bb, nn)),
                   "rand", -1);
        end

`ifdef MONT_CHECK_EN
        @(negedge clk);
        a = 8'd3;
        b = 8'd3;
        n = 8'd12;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("bad_err", err, 1);
        @(negedge clk);
        check("bad_done", done, 1);
        check("bad_result", result, 0);
        run_op(8'd9, 8'd9, 8'd13, 8'd9, "after_bad", -1);
        check("err_clear", err, 0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
